// File: rtl/alu_cmd_scheduler.sv
// alu_cmd_scheduler: round-robin front end for one shared combinational ALU.
// Two requesters compete for the ALU. The granted command's operands are
// registered onto the ALU inputs, the ALU result is captured one cycle later,
// and the result is returned with the requester id over a valid/ready channel.
// Divide/modulus by zero and illegal opcodes are flagged. In those cases the
// ALU result is discarded.
// Build option: define ALU_SCHED_STATS_EN to add saturating counters:
// op_count (response handshakes) and err_count (error responses).
module alu_cmd_scheduler #(
   parameter int unsigned      DATA_W   = 4,
   parameter int unsigned      RES_W    = 8,
   parameter logic [RES_W-1:0] DIV0_VAL = 8'hFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [2:0]        req0_op,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [2:0]        req1_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [2:0]        alu_sel,
   input  logic [RES_W-1:0]  alu_out,
   input  logic              alu_carry,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [RES_W-1:0]  resp_result,
   output logic              resp_carry,
   output logic              resp_id,
   output logic              resp_err
`ifdef ALU_SCHED_STATS_EN
   ,
   output logic [15:0]       op_count,
   output logic [7:0]        err_count
`endif
);

   localparam logic [2:0] OP_DIV = 3'b011;
   localparam logic [2:0] OP_MOD = 3'b100;

   typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_e;

   state_e              state_q;
   logic                rr_last_q;
   logic                id_q;
   logic [DATA_W-1:0]   alu_a_q;
   logic [DATA_W-1:0]   alu_b_q;
   logic [2:0]          alu_sel_q;
   logic                resp_valid_q;
   logic [RES_W-1:0]    resp_result_q;
   logic                resp_carry_q;
   logic                resp_id_q;
   logic                resp_err_q;

   logic                grant0;
   logic                grant1;
   logic [RES_W-1:0]    result_d;
   logic                carry_d;
   logic                err_d;

   // Round-robin grant. A grant is offered only in IDLE. On contention, the
   // requester that was not granted last wins.
   assign grant0 = (state_q == ST_IDLE) && req0_valid && (!req1_valid || rr_last_q);
   assign grant1 = (state_q == ST_IDLE) && req1_valid && (!req0_valid || !rr_last_q);

   assign req0_ready  = grant0;
   assign req1_ready  = grant1;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_sel     = alu_sel_q;
   assign resp_valid  = resp_valid_q;
   assign resp_result = resp_result_q;
   assign resp_carry  = resp_carry_q;
   assign resp_id     = resp_id_q;
   assign resp_err    = resp_err_q;

   // Qualify the settled ALU output. It is trusted only for legal ops that
   // do not fault.
   // NOTE: every variable gets a default first, so no latch can be inferred.
   always_comb begin
      result_d = alu_out;
      carry_d  = alu_carry;
      err_d    = 1'b0;
      if (alu_sel_q > OP_MOD) begin
         result_d = '0;
         carry_d  = 1'b0;
         err_d    = 1'b1;
      end else if ((alu_sel_q == OP_DIV || alu_sel_q == OP_MOD) && alu_b_q == '0) begin
         result_d = DIV0_VAL;
         carry_d  = 1'b0;
         err_d    = 1'b1;
      end
   end

   // Command FSM: IDLE grants a command, EXEC lets the ALU settle and
   // captures the result, RESP holds the response until it is accepted.
   // NOTE: reset is sampled on the clock edge, and all state uses
   // non-blocking assignments so every register updates from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         rr_last_q     <= 1'b1;
         id_q          <= 1'b0;
         alu_a_q       <= '0;
         alu_b_q       <= '0;
         alu_sel_q     <= '0;
         resp_valid_q  <= 1'b0;
         resp_result_q <= '0;
         resp_carry_q  <= 1'b0;
         resp_id_q     <= 1'b0;
         resp_err_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (grant0 || grant1) begin
                  alu_a_q   <= grant1 ? req1_a  : req0_a;
                  alu_b_q   <= grant1 ? req1_b  : req0_b;
                  alu_sel_q <= grant1 ? req1_op : req0_op;
                  id_q      <= grant1;
                  rr_last_q <= grant1;
                  state_q   <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               resp_result_q <= result_d;
               resp_carry_q  <= carry_d;
               resp_err_q    <= err_d;
               resp_id_q     <= id_q;
               resp_valid_q  <= 1'b1;
               state_q       <= ST_RESP;
            end
            ST_RESP: begin
               if (resp_ready) begin
                  resp_valid_q <= 1'b0;
                  state_q      <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

`ifdef ALU_SCHED_STATS_EN
   logic [15:0] op_count_q;
   logic [7:0]  err_count_q;
   logic        handshake;

   assign handshake = (state_q == ST_RESP) && resp_ready;
   assign op_count  = op_count_q;
   assign err_count = err_count_q;

   // Saturating counters: all response handshakes, and those that report an error.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_count_q  <= '0;
         err_count_q <= '0;
      end else if (handshake) begin
         if (op_count_q != '1) op_count_q <= op_count_q + 16'd1;
         if (resp_err_q && err_count_q != '1) err_count_q <= err_count_q + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_cmd_scheduler.sv
// Testbench for alu_cmd_scheduler. A behavioural ALU stand-in drives
// alu_out/alu_carry. Accepted commands push a reference expectation onto a
// scoreboard. Each response handshake pops and compares one entry.
module tb_alu_cmd_scheduler;

   localparam int DATA_W = 4;
   localparam int RES_W  = 8;

   typedef struct packed {
      logic [RES_W-1:0] result;
      logic             carry;
      logic             id;
      logic             err;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              req0_valid, req0_ready;
   logic [DATA_W-1:0] req0_a, req0_b;
   logic [2:0]        req0_op;
   logic              req1_valid, req1_ready;
   logic [DATA_W-1:0] req1_a, req1_b;
   logic [2:0]        req1_op;
   logic [DATA_W-1:0] alu_a, alu_b;
   logic [2:0]        alu_sel;
   logic [RES_W-1:0]  alu_out;
   logic              alu_carry;
   logic              resp_valid, resp_ready;
   logic [RES_W-1:0]  resp_result;
   logic              resp_carry, resp_id, resp_err;
`ifdef ALU_SCHED_STATS_EN
   logic [15:0]       op_count;
   logic [7:0]        err_count;
`endif

   int   vectors     = 0;
   int   miscompares = 0;
   int   hs_count    = 0;
   int   hs_err      = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   alu_cmd_scheduler #(.DATA_W(DATA_W), .RES_W(RES_W), .DIV0_VAL(8'hFF)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_out(alu_out), .alu_carry(alu_carry),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_result(resp_result), .resp_carry(resp_carry),
      .resp_id(resp_id), .resp_err(resp_err)
`ifdef ALU_SCHED_STATS_EN
      , .op_count(op_count), .err_count(err_count)
`endif
   );

   // ALU stand-in. For divide by zero and illegal opcodes it returns junk, so
   // the scheduler must substitute its own values in those cases.
   logic [RES_W:0] ext;
   always_comb begin
      ext       = '0;
      alu_out   = 8'h00;
      alu_carry = 1'b0;
      case (alu_sel)
         3'd0: begin ext = 9'(alu_a) + 9'(alu_b); alu_out = ext[7:0]; alu_carry = ext[4]; end
         3'd1: begin ext = 9'(alu_a) - 9'(alu_b); alu_out = ext[7:0]; alu_carry = ext[8]; end
         3'd2: alu_out = 8'(alu_a) * 8'(alu_b);
         3'd3: alu_out = (alu_b == 4'd0) ? 8'hEE : 8'(alu_a / alu_b);
         3'd4: alu_out = (alu_b == 4'd0) ? 8'hEE : 8'(alu_a % alu_b);
         default: begin alu_out = 8'hA5; alu_carry = 1'b1; end
      endcase
   end

   function automatic exp_t ref_model(input bit id, input int a, input int b, input int op);
      exp_t e;
      e.id = id; e.err = 1'b0; e.carry = 1'b0; e.result = 8'h00;
      case (op)
         0: begin e.result = 8'(a + b); e.carry = (a + b) > 15; end
         1: begin e.result = 8'(a - b); e.carry = (a < b); end
         2: e.result = 8'(a * b);
         3, 4: begin
            if (b == 0) begin e.result = 8'hFF; e.err = 1'b1; end
            else e.result = (op == 3) ? 8'(a / b) : 8'(a % b);
         end
         default: e.err = 1'b1;
      endcase
      return e;
   endfunction

   // Command and response monitor, sampled on the falling edge.
   always @(negedge clk) begin
      exp_t e;
      exp_t got;
      if (!rst) begin
         if (req0_ready || req1_ready) begin
            vectors++;
            if (req0_ready && req1_ready) begin
               miscompares++;
               $display("FAIL both_ready: req0_ready=%b req1_ready=%b, required one-hot", req0_ready, req1_ready);
            end
         end
         if (req0_valid && req0_ready) sb.push_back(ref_model(1'b0, int'(req0_a), int'(req0_b), int'(req0_op)));
         if (req1_valid && req1_ready) sb.push_back(ref_model(1'b1, int'(req1_a), int'(req1_b), int'(req1_op)));
         if (resp_valid && resp_ready) begin
            vectors++;
            got = {resp_result, resp_carry, resp_id, resp_err};
            if (sb.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_resp: got result=%h carry=%b id=%b err=%b, required none",
                        resp_result, resp_carry, resp_id, resp_err);
            end else begin
               e = sb.pop_front();
               hs_count++;
               if (e.err) hs_err++;
               if (got !== e) begin
                  miscompares++;
                  $display("FAIL resp: got result=%h carry=%b id=%b err=%b, required result=%h carry=%b id=%b err=%b",
                           resp_result, resp_carry, resp_id, resp_err, e.result, e.carry, e.id, e.err);
               end
            end
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
      req0_a = '0; req0_b = '0; req0_op = '0; req1_a = '0; req1_b = '0; req1_op = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      sb.delete();
      hs_count = 0; hs_err = 0;
   endtask

   // Waits (bounded) for a ready. Returns at the falling edge where it was seen.
   task automatic wait_grant(output int who);
      int n;
      n = 0; who = -1;
      while (n < 50 && who < 0) begin
         @(negedge clk); n++;
         if (req0_ready) who = 0;
         else if (req1_ready) who = 1;
      end
   endtask

   task automatic drive(input bit id, input int a, input int b, input int op);
      if (id == 1'b0) begin req0_valid = 1'b1; req0_a = 4'(a); req0_b = 4'(b); req0_op = 3'(op); end
      else begin req1_valid = 1'b1; req1_a = 4'(a); req1_b = 4'(b); req1_op = 3'(op); end
   endtask

   task automatic expect_grant(input int exp_who, input string name);
      int who;
      wait_grant(who);
      vectors++;
      if (who != exp_who) begin
         miscompares++;
         $display("FAIL %s: granted=%0d, required %0d", name, who, exp_who);
      end
      @(posedge clk); #1;
      if (exp_who == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
   endtask

   task automatic send(input bit id, input int a, input int b, input int op);
      @(posedge clk); #1;
      drive(id, a, b, op);
      expect_grant(int'(id), "grant");
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (n < 100 && (sb.size() != 0 || resp_valid)) begin @(negedge clk); n++; end
      vectors++;
      if (sb.size() != 0 || resp_valid) begin
         miscompares++;
         $display("FAIL drain_timeout: pending=%0d resp_valid=%b, required 0 and 0", sb.size(), resp_valid);
      end
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if ({alu_a, alu_b, alu_sel} !== '0) begin
         miscompares++;
         $display("FAIL reset_alu: alu_a=%h alu_b=%h alu_sel=%h, required 0", alu_a, alu_b, alu_sel);
      end
      vectors++;
      if ({resp_valid, resp_result, resp_carry, resp_id, resp_err} !== '0) begin
         miscompares++;
         $display("FAIL reset_resp: valid=%b result=%h carry=%b id=%b err=%b, required 0",
                  resp_valid, resp_result, resp_carry, resp_id, resp_err);
      end
   endtask

   task automatic test_single_add();
      @(posedge clk); #1;
      drive(0, 3, 2, 0);
      expect_grant(0, "add_grant");
      vectors++;
      if (resp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL add_exec_valid: resp_valid=%b, required 0", resp_valid);
      end
      @(posedge clk); #1;
      vectors++;
      if ({resp_valid, resp_result, resp_carry, resp_id, resp_err} !== {1'b1, 8'h05, 1'b0, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL add_latency: valid=%b result=%h carry=%b id=%b err=%b, required 1 05 0 0 0",
                  resp_valid, resp_result, resp_carry, resp_id, resp_err);
      end
      @(posedge clk); #1;
      vectors++;
      if (resp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL add_release: resp_valid=%b, required 0", resp_valid);
      end
   endtask

   task automatic test_contention();
      do_reset();
      #0 drive(0, 5, 3, 1);
      drive(1, 3, 2, 2);
      expect_grant(0, "contend_first");
      expect_grant(1, "contend_second");
      wait_drain();
      @(posedge clk); #1;
      drive(0, 1, 2, 0);
      drive(1, 7, 3, 4);
      expect_grant(0, "contend_third");
      expect_grant(1, "contend_fourth");
      wait_drain();
   endtask

   task automatic test_div0();
      send(1, 8, 0, 3);
      send(1, 8, 2, 3);
      send(1, 5, 2, 4);
      send(0, 9, 0, 4);
      wait_drain();
   endtask

   task automatic test_backpressure();
      int n;
      int hs_before;
      @(posedge clk); #1 resp_ready = 1'b0;
      send(0, 15, 15, 0);
      n = 0;
      while (n < 10 && !resp_valid) begin @(negedge clk); n++; end
      @(posedge clk); #1 drive(1, 2, 5, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         vectors++;
         if ({resp_valid, resp_result, resp_carry, resp_id, resp_err, req0_ready, req1_ready} !==
             {1'b1, 8'h1E, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL bp_hold[%0d]: valid=%b result=%h carry=%b id=%b err=%b rdy=%b%b, required 1 1e 1 0 0 rdy=00",
                     i, resp_valid, resp_result, resp_carry, resp_id, resp_err, req0_ready, req1_ready);
         end
      end
      hs_before = hs_count;
      @(posedge clk); #1 resp_ready = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (resp_valid !== 1'b0 || hs_count != hs_before + 1) begin
         miscompares++;
         $display("FAIL bp_single_hs: resp_valid=%b handshakes=%0d, required 0 and %0d",
                  resp_valid, hs_count - hs_before, 1);
      end
      expect_grant(1, "bp_next_grant");
      wait_drain();
   endtask

   task automatic test_illegal_reset();
      send(0, 1, 1, 7);
      send(1, 6, 3, 5);
      wait_drain();
      send(0, 4, 4, 0);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      vectors++;
      if ({alu_a, alu_b, alu_sel, resp_valid, resp_result, resp_carry, resp_id, resp_err, req0_ready, req1_ready} !== '0) begin
         miscompares++;
         $display("FAIL midop_reset: alu=%h/%h/%h valid=%b result=%h carry=%b id=%b err=%b, required all 0",
                  alu_a, alu_b, alu_sel, resp_valid, resp_result, resp_carry, resp_id, resp_err);
      end
      vectors++;
      if (sb.size() != 1) begin
         miscompares++;
         $display("FAIL midop_pending: pending=%0d, required 1", sb.size());
      end
      sb.delete();
      hs_count = 0; hs_err = 0;
      repeat (3) @(negedge clk);
      vectors++;
      if (resp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL midop_no_resp: resp_valid=%b, required 0", resp_valid);
      end
      @(posedge clk); #1;
      drive(0, 2, 2, 2);
      drive(1, 2, 3, 0);
      expect_grant(0, "post_reset_grant");
      expect_grant(1, "post_reset_second");
      wait_drain();
   endtask

`ifdef ALU_SCHED_STATS_EN
   task automatic test_stats();
      vectors++;
      if (op_count !== 16'(hs_count) || err_count !== 8'(hs_err)) begin
         miscompares++;
         $display("FAIL stats_count: op_count=%0d err_count=%0d, required %0d %0d", op_count, err_count, hs_count, hs_err);
      end
      for (int i = 0; i < 260; i++) send(i[0], 1, 0, 3);
      wait_drain();
      vectors++;
      if (err_count !== 8'hFF || op_count !== 16'(hs_count)) begin
         miscompares++;
         $display("FAIL stats_saturate: err_count=%h op_count=%0d, required ff %0d", err_count, op_count, hs_count);
      end
   endtask
`endif

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_add();
      test_contention();
      test_div0();
      test_backpressure();
      test_illegal_reset();
`ifdef ALU_SCHED_STATS_EN
      test_stats();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
